fifo_ram: RTL and testbench
===========================

// Module: fifo_ram
// PURPOSE
//  Simple dual-port RAM: one write port and one registered read port on one clock.
//  It is the storage core under FIFOs, flit buffers and the DfD trace buffer.
//  The parent owns the read/write pointers and passes raw addresses in.
//  Optional same-cycle read-during-write bypass (SSA_EN) gives write-first semantics.
// PARAMETERS
//  DATA_WIDTH  32     word width in bits
//  ADDR_WIDTH  4      address bits; depth = 2**ADDR_WIDTH words
//  SSA_EN      "NO"   "YES" = forward wr_data on same-address read/write; "NO" = read-first
// PORTS
//  clk      in   1            sole clock; all state updates on posedge
//  reset    in   1            asynchronous, active-high; clears read-side registers
//  wr_data  in   DATA_WIDTH   write data
//  wr_addr  in   ADDR_WIDTH   write address
//  wr_en    in   1            write strobe: mem[wr_addr] <= wr_data at posedge
//  rd_addr  in   ADDR_WIDTH   read address
//  rd_en    in   1            read strobe: captures mem[rd_addr] into the output register
//  rd_data  out  DATA_WIDTH   registered read data
// BEHAVIOUR
//  - Reset (async, high):
//    - rd_data register <= 0.
//    - bypass flag <= 0.
//    - memory array is NOT cleared; contents are undefined until written.
//  - Write: wr_en=1 at posedge writes the word; wr_en=0 leaves memory unchanged.
//  - Read:
//    - rd_en=1 at posedge loads rd_data with mem[rd_addr]; latency is one clock.
//    - rd_en=0 holds rd_data at its previous value.
//  - Read and write to different addresses in the same cycle: independent, no interaction.
//  - Read and write to the same address in the same cycle:
//    - SSA_EN="NO": rd_data gets the OLD word (read-first); the new word is stored.
//    - SSA_EN="YES":
//      - At that edge register bypass_reg <= wr_data and bypass_flag <= 1.
//      - rd_data = bypass_flag ? bypass_reg : mem_out_reg, so the reader sees the NEW word.
//      - bypass_flag is re-evaluated every cycle: it is set only when rd_en&wr_en&(rd_addr==wr_addr).
//      - A later rd_en without collision clears it; the flag also clears on any cycle where rd_en=0.
//      - On such rd_en=0 cycles mem_out_reg holds the word written at the collision edge,
//        so rd_data still shows the new word.
//  - Addresses are plain binary indices; wrap-around is the caller's job (pointer overflow).
//  - No full/empty tracking and no bounds checks: the parent FIFO logic owns them.
//  - Any SSA_EN value other than "YES" behaves as "NO".
//  - Reset asserted mid-operation: rd_data goes to 0 immediately (asynchronously).
//    A write on the same edge as reset release is honoured.
//  - Inferrable as block RAM: synchronous write, synchronous registered read, no reset on the array.
// TESTING
//  1. Reset=1 -> rd_data==0. Release reset, write 0xA5A5A5A5@3, then rd_en@3 -> rd_data==0xA5A5A5A5 one clock later.
//  2. Fill addrs 0..15 with value addr*0x11, read back 0..15 -> each word appears 1 cycle after its rd_en.
//     With rd_en=0 in between, rd_data holds the last value.
//  3. SSA_EN="NO": mem[5]=0x1; same cycle wr 0x2@5 and rd@5 -> rd_data==0x1.
//     Next read @5 -> 0x2.
//  4. SSA_EN="YES", same stimulus as 3 -> rd_data==0x2 immediately after the edge.
//     A following rd@6 (no collision) -> mem[6].
//  5. Simultaneous wr@2 / rd@7 -> rd_data==old mem[7]; mem[2] updated (verify by a later read).
//  6. Assert reset while rd_data==0xDEADBEEF, between clock edges -> rd_data==0 before the next posedge.
//     Memory contents are retained after reset.

Source files
------------

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM with one write port and one registered read port.
// It is the storage core under FIFOs and trace buffers; the parent owns the pointers.
// Ports:
//   clk      - sole clock, all updates on posedge
//   reset    - asynchronous active-high, clears read-side registers only
//   wr_data  - write data
//   wr_addr  - write address
//   wr_en    - write strobe
//   rd_addr  - read address
//   rd_en    - read strobe, loads the output register
//   rd_data  - read data, one clock after rd_en
// SSA_EN = "YES" forwards wr_data on a same-address read/write (write-first);
// any other value gives read-first behaviour.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter string       SSA_EN     = "NO"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam bit          BYPASS = (SSA_EN == "YES");

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_out_q, mem_out_d;
  logic [DATA_WIDTH-1:0] bypass_q, bypass_d;
  logic                  flag_q, flag_d;
  logic                  collide_c;

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign collide_c = BYPASS && rd_en && wr_en && (rd_addr == wr_addr);

  // Read-side next state; the bypass flag is re-evaluated every cycle.
  always_comb begin
    mem_out_d = mem_out_q;
    bypass_d  = bypass_q;
    flag_d    = 1'b0;
    if (rd_en) begin
      if (collide_c) begin
        // Output register also takes the new word so a later idle cycle keeps showing it.
        mem_out_d = wr_data;
        bypass_d  = wr_data;
        flag_d    = 1'b1;
      end else begin
        mem_out_d = mem_q[rd_addr];
      end
    end
  end

  // Read-side registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_out_q <= '0;
      bypass_q  <= '0;
      flag_q    <= 1'b0;
    end else begin
      mem_out_q <= mem_out_d;
      bypass_q  <= bypass_d;
      flag_q    <= flag_d;
    end
  end

  assign rd_data = flag_q ? bypass_q : mem_out_q;

endmodule

// File: tb/tb_fifo_ram.sv
// tb_fifo_ram: drives one read-first and one write-first instance with shared
// stimulus and compares both outputs against a scoreboard built from a memory model.
module tb_fifo_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wr_data;
  logic [3:0]  wr_addr;
  logic        wr_en;
  logic [3:0]  rd_addr;
  logic        rd_en;
  logic [31:0] rd_no;
  logic [31:0] rd_yes;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m [16];
  logic [31:0] q_no[$];
  logic [31:0] q_yes[$];
  logic [31:0] prev_no;
  logic [31:0] prev_yes;

  always #5 clk = ~clk;

  fifo_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .SSA_EN("NO")) dut_no (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_no)
  );

  fifo_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .SSA_EN("YES")) dut_yes (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_yes)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; expected outputs are queued before the edge and checked after it.
  task automatic cyc(input string tag, input logic we, input logic [3:0] wa,
                     input logic [31:0] wd, input logic re, input logic [3:0] ra);
    logic [31:0] e_no;
    logic [31:0] e_yes;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    e_no  = re ? m[ra] : prev_no;
    e_yes = re ? ((we && (wa == ra)) ? wd : m[ra]) : prev_yes;
    q_no.push_back(e_no);
    q_yes.push_back(e_yes);
    prev_no  = e_no;
    prev_yes = e_yes;
    if (we) m[wa] = wd;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_eq({tag, "_no"}, rd_no, q_no.pop_front());
    check_eq({tag, "_yes"}, rd_yes, q_yes.pop_front());
  endtask

  initial begin
    reset   = 1'b1;
    wr_data = '0;
    wr_addr = '0;
    wr_en   = 1'b0;
    rd_addr = '0;
    rd_en   = 1'b0;
    prev_no  = '0;
    prev_yes = '0;
    for (int i = 0; i < 16; i++) m[i] = '0;

    // Reset value
    #12;
    check_eq("reset_no", rd_no, 32'h0);
    check_eq("reset_yes", rd_yes, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic write then read
    cyc("wr3", 1'b1, 4'd3, 32'hA5A5_A5A5, 1'b0, 4'd0);
    cyc("rd3", 1'b0, 4'd0, 32'h0, 1'b1, 4'd3);

    // Fill and read back, with hold cycles in between
    for (int a = 0; a < 16; a++) cyc("fill", 1'b1, 4'(a), 32'(a * 17), 1'b0, 4'd0);
    for (int a = 0; a < 16; a++) begin
      cyc("rdback", 1'b0, 4'd0, 32'h0, 1'b1, 4'(a));
      cyc("hold", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    end

    // Same-address collision: read-first vs write-first
    cyc("pre5", 1'b1, 4'd5, 32'h1, 1'b0, 4'd0);
    cyc("coll5", 1'b1, 4'd5, 32'h2, 1'b1, 4'd5);
    cyc("collhold", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    cyc("re5", 1'b0, 4'd0, 32'h0, 1'b1, 4'd5);
    cyc("coll5b", 1'b1, 4'd5, 32'h3, 1'b1, 4'd5);
    cyc("rd6", 1'b0, 4'd0, 32'h0, 1'b1, 4'd6);
    cyc("re5b", 1'b0, 4'd0, 32'h0, 1'b1, 4'd5);

    // Different addresses in the same cycle
    cyc("wr2rd7", 1'b1, 4'd2, 32'h2222_2222, 1'b1, 4'd7);
    cyc("rd2", 1'b0, 4'd0, 32'h0, 1'b1, 4'd2);

    // Asynchronous reset between edges; memory must survive
    cyc("wr9", 1'b1, 4'd9, 32'hDEAD_BEEF, 1'b0, 4'd0);
    cyc("rd9", 1'b0, 4'd0, 32'h0, 1'b1, 4'd9);
    #3;
    reset = 1'b1;
    #1;
    check_eq("async_rst_no", rd_no, 32'h0);
    check_eq("async_rst_yes", rd_yes, 32'h0);
    #1;
    reset = 1'b0;
    prev_no  = '0;
    prev_yes = '0;
    @(posedge clk);
    #1;
    check_eq("post_rst_no", rd_no, 32'h0);
    check_eq("post_rst_yes", rd_yes, 32'h0);
    cyc("rd9_after", 1'b0, 4'd0, 32'h0, 1'b1, 4'd9);
    cyc("rd2_after", 1'b0, 4'd0, 32'h0, 1'b1, 4'd2);

    // Random mixed traffic over the fully written array
    for (int n = 0; n < 60; n++) begin
      cyc("rand", 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom,
          1'($urandom_range(1)), 4'($urandom_range(15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
